// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encoding and select constants for the round-robin mux arbiter
package mux_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Ownership state that corresponds to a select value
    function automatic state_t own_state(input logic side);
        return (side == SEL_B) ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/mux2to1_w.sv
// mux2to1_w: WIDTH-bit 2:1 combinational mux (sel = 0 picks a, sel = 1 picks b)
module mux2to1_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: burst round-robin arbiter sharing one 2:1 mux between two valid/ready sources
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             y_valid_q, y_valid_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic [WIDTH-1:0] mux_y;
    logic             owner, own_valid, oth_valid, load, accept;
    logic             enter, side;

    // The owner is the side named by the state; sel mirrors it while a grant is held
    assign owner     = (state_q == OWN_B);
    assign own_valid = owner ? b_valid : a_valid;
    assign oth_valid = owner ? a_valid : b_valid;
    assign load      = !y_valid_q || y_ready;
    assign a_ready   = (state_q == OWN_A) && load;
    assign b_ready   = (state_q == OWN_B) && load;
    assign accept    = (state_q != IDLE) && own_valid && load;

    mux2to1_w #(.WIDTH(WIDTH)) u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (sel_q),
        .y   (mux_y)
    );

    // Arbitration: pick a new owner from IDLE, on owner drop, or at burst end
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        enter   = 1'b0;
        side    = sel_q;
        if (state_q == IDLE) begin
            enter = a_valid || b_valid;
            side  = (a_valid && b_valid) ? ~last_q : (b_valid ? SEL_B : SEL_A);
        end else if (!own_valid) begin
            enter   = oth_valid;
            side    = ~owner;
            state_d = oth_valid ? state_q : IDLE;
        end else if (load) begin
            enter = (cnt_q == CNT_MAX);
            side  = oth_valid ? ~owner : owner;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        if (enter) begin
            state_d = own_state(side);
            sel_d   = side;
            last_d  = side;
            cnt_d   = '0;
        end
    end

    // Output stage: capture the mux on an accepted beat, drain when the consumer takes it
    always_comb begin
        y_valid_d = accept ? 1'b1 : (y_ready ? 1'b0 : y_valid_q);
        y_data_d  = accept ? mux_y : y_data_q;
    end

    // All state registers; last resets to B so the first contested grant goes to A
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= SEL_A;
            last_q    <= SEL_B;
            cnt_q     <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign sel     = sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed bench with a transaction-level model for BURST=4 and BURST=1 instances
module tb_mux2_rr_arbiter;

    logic       clk, rst_n;
    logic       av[2], bv[2], ar[2], br[2], yv[2], yr[2], sl[2];
    logic [7:0] ad[2], bd[2], yd[2];

    int a_sent[2], a_total[2], a_base[2], a_off[2];
    int b_sent[2], b_total[2], b_base[2], b_off[2];
    bit acc_a[2], acc_b[2];

    int total = 0, bad = 0, cyc = 0;
    int lg0[$], lc0[$], lg1[$], lc1[$];

    // Model: owner 0 = none, 1 = A, 2 = B; taken = beats granted in the current burst
    int m_own[2], m_taken[2], m_last[2], m_sel[2], m_yv[2], m_yd[2];
    int burst[2] = '{4, 1};

    // Counting producers: each source offers base, base+1, ... until its quota is met
    for (genvar g = 0; g < 2; g++) begin : g_src
        assign av[g] = a_sent[g] < a_total[g];
        assign bv[g] = b_sent[g] < b_total[g];
        assign ad[g] = 8'(a_base[g] + a_sent[g] - a_off[g]);
        assign bd[g] = 8'(b_base[g] + b_sent[g] - b_off[g]);
    end

    mux2_rr_arbiter #(.WIDTH(8), .BURST(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(av[0]), .a_data(ad[0]), .a_ready(ar[0]),
        .b_valid(bv[0]), .b_data(bd[0]), .b_ready(br[0]),
        .y_valid(yv[0]), .y_data(yd[0]), .y_ready(yr[0]), .sel(sl[0])
    );

    mux2_rr_arbiter #(.WIDTH(8), .BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(av[1]), .a_data(ad[1]), .a_ready(ar[1]),
        .b_valid(bv[1]), .b_data(bd[1]), .b_ready(br[1]),
        .y_valid(yv[1]), .y_data(yd[1]), .y_ready(yr[1]), .sel(sl[1])
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model on the current inputs
    always @(negedge clk) begin
        int ld, aa, ba, ownv, othv, nxt;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_own[k] = 0; m_taken[k] = 0; m_last[k] = 2; m_sel[k] = 0; m_yv[k] = 0; m_yd[k] = 0;
            end
            ld = (m_yv[k] == 0 || yr[k]) ? 1 : 0;
            chk($sformatf("a_ready%0d", k), int'(ar[k]), (m_own[k] == 1 && ld == 1) ? 1 : 0);
            chk($sformatf("b_ready%0d", k), int'(br[k]), (m_own[k] == 2 && ld == 1) ? 1 : 0);
            chk($sformatf("ready_excl%0d", k), int'(ar[k] && br[k]), 0);
            chk($sformatf("sel%0d", k), int'(sl[k]), m_sel[k]);
            chk($sformatf("y_valid%0d", k), int'(yv[k]), m_yv[k]);
            chk($sformatf("y_data%0d", k), int'(yd[k]), m_yd[k]);
            if (yv[k] && yr[k]) begin
                if (k == 0) begin lg0.push_back(int'(yd[k])); lc0.push_back(cyc); end
                else begin lg1.push_back(int'(yd[k])); lc1.push_back(cyc); end
            end
            aa = (rst_n && m_own[k] == 1 && av[k] && ld == 1) ? 1 : 0;
            ba = (rst_n && m_own[k] == 2 && bv[k] && ld == 1) ? 1 : 0;
            acc_a[k] = aa == 1;
            acc_b[k] = ba == 1;
            if (rst_n) begin
                if (aa == 1 || ba == 1) begin
                    m_yd[k] = (aa == 1) ? int'(ad[k]) : int'(bd[k]);
                    m_yv[k] = 1;
                end else if (yr[k]) m_yv[k] = 0;
                ownv = (m_own[k] == 1) ? int'(av[k]) : int'(bv[k]);
                othv = (m_own[k] == 1) ? int'(bv[k]) : int'(av[k]);
                nxt = m_own[k];
                if (m_own[k] == 0)
                    nxt = (av[k] && bv[k]) ? (m_last[k] == 2 ? 1 : 2) : (av[k] ? 1 : (bv[k] ? 2 : 0));
                else if (ownv == 0)
                    nxt = (othv == 1) ? 3 - m_own[k] : 0;
                else if (aa == 1 || ba == 1) begin
                    m_taken[k]++;
                    if (m_taken[k] == burst[k]) begin
                        m_taken[k] = 0;
                        nxt = (othv == 1) ? 3 - m_own[k] : m_own[k];
                    end
                end
                if (nxt != m_own[k] && nxt != 0) begin
                    m_taken[k] = 0;
                    m_last[k] = nxt;
                    m_sel[k] = nxt - 1;
                end
                m_own[k] = nxt;
            end
        end
    end

    // Producers advance after each edge on the beats accepted in the previous cycle
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            if (acc_a[k]) a_sent[k]++;
            if (acc_b[k]) b_sent[k]++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic start_a(input int k, input int base, input int n);
        a_base[k] = base; a_off[k] = a_sent[k]; a_total[k] = a_sent[k] + n;
    endtask

    task automatic start_b(input int k, input int base, input int n);
        b_base[k] = base; b_off[k] = b_sent[k]; b_total[k] = b_sent[k] + n;
    endtask

    initial begin
        int n0, t0;
        int exp3[16] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                         8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        int exp5[7] = '{8'h50, 8'h60, 8'h51, 8'h61, 8'h62, 8'h63, 8'h64};
        int exp6[6] = '{8'h80, 8'h81, 8'h72, 8'h73, 8'h74, 8'h75};
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            a_sent[k] = 0; a_total[k] = 0; a_base[k] = 0; a_off[k] = 0;
            b_sent[k] = 0; b_total[k] = 0; b_base[k] = 0; b_off[k] = 0;
            yr[k] = 1;
        end
        // reset values
        step(3);
        chk("rst_y_valid", int'(yv[0]), 0);
        chk("rst_y_data", int'(yd[0]), 0);
        chk("rst_sel", int'(sl[0]), 0);
        chk("rst_ready", int'(ar[0] || br[0] || ar[1] || br[1]), 0);
        rst_n = 1;
        step(1);
        // A only, 6 beats
        start_a(0, 8'h10, 6);
        t0 = cyc + 1;
        n0 = lg0.size();
        step(12);
        chk("t2_count", lg0.size() - n0, 6);
        if (lg0.size() - n0 == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("t2_beat%0d", i), lg0[n0 + i], 8'h10 + i);
            chk("t2_latency", lc0[n0] - t0, 2);
            chk("t2_back2back", lc0[n0 + 5] - lc0[n0], 5);
        end
        // A and B both streaming, bursts of 4
        start_a(0, 8'hA0, 8);
        step(1);
        start_b(0, 8'hB0, 8);
        n0 = lg0.size();
        step(24);
        chk("t3_count", lg0.size() - n0, 16);
        if (lg0.size() - n0 == 16) begin
            for (int i = 0; i < 16; i++) chk($sformatf("t3_beat%0d", i), lg0[n0 + i], exp3[i]);
            chk("t3_no_bubble", lc0[n0 + 15] - lc0[n0], 15);
        end
        // consumer stall mid-burst
        start_a(0, 8'h40, 8);
        n0 = lg0.size();
        step(3);
        yr[0] = 0;
        step(2);
        chk("t4_stall_ready", int'(ar[0]), 0);
        chk("t4_stall_valid", int'(yv[0]), 1);
        chk("t4_stall_sel", int'(sl[0]), 0);
        step(3);
        yr[0] = 1;
        step(12);
        chk("t4_count", lg0.size() - n0, 8);
        if (lg0.size() - n0 == 8)
            for (int i = 0; i < 8; i++) chk($sformatf("t4_beat%0d", i), lg0[n0 + i], 8'h40 + i);
        // BURST=1 alternation, A drops after 2 beats
        start_a(1, 8'h50, 2);
        start_b(1, 8'h60, 5);
        n0 = lg1.size();
        step(12);
        chk("t5_count", lg1.size() - n0, 7);
        if (lg1.size() - n0 == 7) begin
            for (int i = 0; i < 7; i++) chk($sformatf("t5_beat%0d", i), lg1[n0 + i], exp5[i]);
            chk("t5_no_idle", lc1[n0 + 6] - lc1[n0], 6);
        end
        // reset in OWN_B with two beats of the burst taken
        start_b(0, 8'h70, 6);
        step(3);
        chk("t6_pre_sel", int'(sl[0]), 1);
        rst_n = 0;
        #1;
        chk("t6_async_y_valid", int'(yv[0]), 0);
        chk("t6_async_sel", int'(sl[0]), 0);
        start_a(0, 8'h80, 2);
        n0 = lg0.size();
        step(1);
        rst_n = 1;
        step(14);
        chk("t6_count", lg0.size() - n0, 6);
        if (lg0.size() - n0 == 6)
            for (int i = 0; i < 6; i++) chk($sformatf("t6_beat%0d", i), lg0[n0 + i], exp6[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
